// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the RAM port arbiter
package mem_arb_pkg;

   localparam int ARB_AW = 8;
   localparam int ARB_DW = 8;

   typedef enum logic [2:0] {
      RUN,
      DRAIN,
      P_IDLE,
      P_ACC,
      P_WAIT,
      P_HOLD,
      RELEASE
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - programmer req/gnt/done access port of the RAM arbiter
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = ARB_AW,
   parameter int DW = ARB_DW
) ();

   logic          pr_req;
   logic          pr_wr;
   logic [AW-1:0] pr_adrs;
   logic [DW-1:0] pr_wdata;
   logic          pr_gnt;
   logic          pr_done;
   logic [DW-1:0] pr_rdata;

   modport master (
      output pr_req, pr_wr, pr_adrs, pr_wdata,
      input  pr_gnt, pr_done, pr_rdata
   );

   modport slave (
      input  pr_req, pr_wr, pr_adrs, pr_wdata,
      output pr_gnt, pr_done, pr_rdata
   );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage single-bit synchronizer with synchronous reset
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clock) begin
      if (reset) begin
         ff <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - hands the single-port RAM between the CDEC8 core and the programmer
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW          = ARB_AW,
   parameter int DW          = ARB_DW,
   parameter int DRAIN_MAX   = 15,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          mode_sw,
   input  logic [AW-1:0] cpu_adrs,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_wr_en,
   input  logic          cpu_endseq,
   output logic          cpu_stall,
   mem_port_arbiter_if.slave pr,
   output logic [AW-1:0] mem_adrs,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr_en,
   input  logic [DW-1:0] mem_q,
   output logic          prog_mode
);

   localparam int            CW      = $clog2(DRAIN_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_MAX);

   arb_state_e    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic          mode_sync;
   logic          cap_wr;
   logic [AW-1:0] cap_adrs;
   logic [DW-1:0] cap_wdata;
   logic          gnt_q;
   logic          done_q;
   logic [DW-1:0] rdata_q;
   logic          accept;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_mode_sync (
      .clock (clock),
      .reset (reset),
      .d     (mode_sw),
      .q     (mode_sync)
   );

   assign accept = (state == P_IDLE) && pr.pr_req;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      case (state)
         RUN: begin
            if (mode_sync) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Counting the incremented value bounds DRAIN to DRAIN_MAX cycles.
            cnt_nxt = cnt_inc;
            if (!mode_sync) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else if (cpu_endseq || (cnt_inc == CNT_MAX)) begin
               state_nxt = P_IDLE;
               cnt_nxt   = '0;
            end
         end
         P_IDLE: begin
            if (pr.pr_req)       state_nxt = P_ACC;
            else if (!mode_sync) state_nxt = RELEASE;
         end
         P_ACC:   state_nxt = P_WAIT;
         P_WAIT:  state_nxt = P_HOLD;
         P_HOLD: begin
            // A request held past done must drop before another is accepted.
            if (!pr.pr_req) state_nxt = P_IDLE;
         end
         RELEASE: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      mem_adrs  = cap_adrs;
      mem_wdata = cap_wdata;
      mem_wr_en = 1'b0;
      case (state)
         RUN, DRAIN: begin
            mem_adrs  = cpu_adrs;
            mem_wdata = cpu_wdata;
            mem_wr_en = cpu_wr_en;
         end
         P_ACC:   mem_wr_en = cap_wr;
         default: mem_wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RUN;
         cnt       <= '0;
         cap_wr    <= 1'b0;
         cap_adrs  <= '0;
         cap_wdata <= '0;
         gnt_q     <= 1'b0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         gnt_q  <= accept;
         done_q <= (state == P_WAIT);
         if (accept) begin
            cap_wr    <= pr.pr_wr;
            cap_adrs  <= pr.pr_adrs;
            cap_wdata <= pr.pr_wdata;
         end
         // mem_q carries the word addressed in P_ACC during P_WAIT.
         if ((state == P_WAIT) && !cap_wr) begin
            rdata_q <= mem_q;
         end
      end
   end

   assign cpu_stall   = (state != RUN) && (state != DRAIN);
   assign prog_mode   = cpu_stall;
   assign pr.pr_gnt   = gnt_q;
   assign pr.pr_done  = done_q;
   assign pr.pr_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter handover and programmer access
module tb_mem_port_arbiter;

   logic       clock;
   logic       reset;
   logic       mode_sw;
   logic [7:0] cpu_adrs;
   logic [7:0] cpu_wdata;
   logic       cpu_wr_en;
   logic       cpu_endseq;
   logic       cpu_stall;
   logic [7:0] mem_adrs;
   logic [7:0] mem_wdata;
   logic       mem_wr_en;
   logic [7:0] mem_q;
   logic       prog_mode;

   mem_port_arbiter_if pr ();

   mem_port_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .mode_sw    (mode_sw),
      .cpu_adrs   (cpu_adrs),
      .cpu_wdata  (cpu_wdata),
      .cpu_wr_en  (cpu_wr_en),
      .cpu_endseq (cpu_endseq),
      .cpu_stall  (cpu_stall),
      .pr         (pr),
      .mem_adrs   (mem_adrs),
      .mem_wdata  (mem_wdata),
      .mem_wr_en  (mem_wr_en),
      .mem_q      (mem_q),
      .prog_mode  (prog_mode)
   );

   logic [7:0] ram [256];
   logic [7:0] ram_model [256];
   logic [7:0] model_rdata;
   logic [7:0] sb_q [$];
   int         n_vec;
   int         n_err;
   int         pr_wr_cnt;
   int         gnt_cnt;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_wr_en) ram[mem_adrs] <= mem_wdata;
      mem_q <= ram[mem_adrs];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      logic [7:0] e;
      if (pr.pr_done) begin
         if (sb_q.size() == 0) begin
            check("done_unexpected", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("rdata", pr.pr_rdata, e);
         end
      end
      if (mem_wr_en && prog_mode) pr_wr_cnt++;
      if (pr.pr_gnt) gnt_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_prog(input logic exp, input int max_cycles);
      int n;
      n = 0;
      while ((prog_mode !== exp) && (n < max_cycles)) begin
         tick();
         n++;
      end
      check("prog_wait", prog_mode, exp);
   endtask

   task automatic pr_access(input logic wr, input logic [7:0] a, input logic [7:0] d, input int hold);
      int n;
      int w0;
      int g0;
      w0 = pr_wr_cnt;
      g0 = gnt_cnt;
      pr.pr_req   = 1'b1;
      pr.pr_wr    = wr;
      pr.pr_adrs  = a;
      pr.pr_wdata = d;
      if (!wr) model_rdata = ram_model[a];
      sb_q.push_back(model_rdata);
      if (wr) ram_model[a] = d;
      n = 0;
      tick();
      while (!pr.pr_gnt && n < 8) begin
         tick();
         n++;
      end
      check("gnt_lat", n, 0);
      check("acc_wr_en", mem_wr_en, wr);
      check("acc_adrs", mem_adrs, a);
      if (wr) check("acc_wdata", mem_wdata, d);
      n = 0;
      do begin
         tick();
         n++;
      end while (!pr.pr_done && n < 8);
      check("done_lat", n, 2);
      repeat (hold) tick();
      pr.pr_req = 1'b0;
      tick();
      check("wr_pulses", pr_wr_cnt - w0, wr ? 1 : 0);
      check("gnt_pulses", gnt_cnt - g0, 1);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      pr_wr_cnt = 0;
      gnt_cnt = 0;
      model_rdata = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ram[i] = 8'h00;
         ram_model[i] = 8'h00;
      end
      reset = 1'b1;
      mode_sw = 1'b0;
      cpu_adrs = 8'h00;
      cpu_wdata = 8'h00;
      cpu_wr_en = 1'b0;
      cpu_endseq = 1'b0;
      pr.pr_req = 1'b0;
      pr.pr_wr = 1'b0;
      pr.pr_adrs = 8'h00;
      pr.pr_wdata = 8'h00;
      repeat (3) tick();
      check("rst_stall", cpu_stall, 0);
      check("rst_prog", prog_mode, 0);
      check("rst_gnt", pr.pr_gnt, 0);
      check("rst_done", pr.pr_done, 0);
      check("rst_rdata", pr.pr_rdata, 0);
      reset = 1'b0;

      cpu_adrs = 8'h10;
      cpu_wdata = 8'hA5;
      cpu_wr_en = 1'b1;
      tick();
      check("run_wr_en", mem_wr_en, 1);
      check("run_adrs", mem_adrs, 8'h10);
      check("run_wdata", mem_wdata, 8'hA5);
      check("run_stall", cpu_stall, 0);
      check("run_prog", prog_mode, 0);

      // run -> program with endseq on the 3rd DRAIN cycle
      mode_sw = 1'b1;
      repeat (5) tick();
      check("drain3_stall", cpu_stall, 0);
      cpu_endseq = 1'b1;
      tick();
      cpu_endseq = 1'b0;
      check("endseq_stall", cpu_stall, 1);
      check("endseq_prog", prog_mode, 1);
      check("pidle_wr_blk", mem_wr_en, 0);

      pr_access(1'b1, 8'h20, 8'h3C, 0);
      pr_access(1'b0, 8'h20, 8'h00, 0);
      pr_access(1'b1, 8'h30, 8'h77, 10);
      pr_access(1'b0, 8'h30, 8'h00, 0);

      // program -> run takes SYNC_STAGES + 2 cycles
      mode_sw = 1'b0;
      repeat (3) tick();
      check("release_stall", cpu_stall, 1);
      check("release_wr_blk", mem_wr_en, 0);
      tick();
      check("back_run_stall", cpu_stall, 0);
      check("back_run_wr", mem_wr_en, 1);

      // forced handover after DRAIN_MAX drain cycles
      mode_sw = 1'b1;
      repeat (17) tick();
      check("drain15_stall", cpu_stall, 0);
      tick();
      check("forced_stall", cpu_stall, 1);

      // reset during P_ACC drops the access
      pr.pr_req = 1'b1;
      pr.pr_wr = 1'b1;
      pr.pr_adrs = 8'h40;
      pr.pr_wdata = 8'h99;
      tick();
      check("pacc_gnt", pr.pr_gnt, 1);
      reset = 1'b1;
      pr.pr_req = 1'b0;
      tick();
      reset = 1'b0;
      check("rst_acc_stall", cpu_stall, 0);
      check("rst_acc_prog", prog_mode, 0);
      check("rst_acc_done", pr.pr_done, 0);
      check("rst_acc_rdata", pr.pr_rdata, 0);
      model_rdata = 8'h00;
      repeat (3) tick();
      wait_prog(1'b1, 40);

      // mode_sw falls during P_WAIT: access completes, then RELEASE, then RUN
      model_rdata = ram_model[8'h20];
      sb_q.push_back(model_rdata);
      pr.pr_req = 1'b1;
      pr.pr_wr = 1'b0;
      pr.pr_adrs = 8'h20;
      tick();
      check("late_gnt", pr.pr_gnt, 1);
      tick();
      mode_sw = 1'b0;
      tick();
      check("late_done", pr.pr_done, 1);
      pr.pr_req = 1'b0;
      tick();
      check("late_idle_stall", cpu_stall, 1);
      tick();
      check("late_rel_stall", cpu_stall, 1);
      check("late_rel_wr", mem_wr_en, 0);
      tick();
      check("late_run_stall", cpu_stall, 0);

      repeat (4) tick();
      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Owns the single-port program/data RAM and shares it between the CDEC8 core and the memory programmer. Replaces the raw mode-switch muxing in front of the RAM with a sequenced ownership handover. Synchronizes the mode switch, drains the CPU to an instruction boundary, and serves programmer read/write requests through a one-outstanding req/gnt/done handshake.

Parameters:
AW, 8, RAM address width
DW, 8, RAM data width
DRAIN_MAX, 15, maximum cycles to wait for cpu_endseq before forcing handover (counter width = clog2(DRAIN_MAX+1))
SYNC_STAGES, 2, flip-flop stages on the mode_sw input

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
mode_sw  in  1  raw mode switch: 1 = program, 0 = run; asynchronous to clock
cpu_adrs  in  AW  CPU memory address
cpu_wdata  in  DW  CPU write data
cpu_wr_en  in  1  CPU write enable
cpu_endseq  in  1  CPU at an instruction boundary
cpu_stall  out  1  CPU must hold state; high whenever the CPU does not own the RAM
pr_req  in  1  programmer access request; level, held until pr_done
pr_wr  in  1  1 = write, 0 = read; sampled with pr_req
pr_adrs  in  AW  programmer address
pr_wdata  in  DW  programmer write data
pr_gnt  out  1  one-cycle pulse: request accepted and inputs captured
pr_done  out  1  one-cycle pulse: access complete, pr_rdata valid
pr_rdata  out  DW  read data; holds its value until the next pr_done
mem_adrs  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_wr_en  out  1  RAM write enable
mem_q  in  DW  RAM registered read data; one-cycle latency
prog_mode  out  1  1 = programmer owns the RAM (display and LED qualifier)

Behaviour:
- Reset: state = RUN. cpu_stall = 0, pr_gnt = 0, pr_done = 0, pr_rdata = 0, prog_mode = 0, synchronizer flops = 0, drain counter = 0.
- mode_sync is the last synchronizer stage. Only mode_sync is used downstream.
- RUN: mem_* = cpu_*. cpu_stall = 0. If mode_sync = 1, go to DRAIN.
- DRAIN: mem_* = cpu_*; the CPU finishes its current cycle. The counter increments every cycle.
  - If cpu_endseq = 1 or counter = DRAIN_MAX, go to P_IDLE and clear the counter.
  - If mode_sync drops to 0 first, go back to RUN and clear the counter.
- From P_IDLE onward, cpu_stall = 1 and prog_mode = 1. In every state except RUN, DRAIN and P_ACC, mem_wr_en = 0.
- P_IDLE:
  - If pr_req = 1: capture pr_wr, pr_adrs and pr_wdata; pulse pr_gnt; go to P_ACC.
  - Otherwise, if mode_sync = 0, go to RELEASE.
  - If pr_req and mode_sync = 0 arrive together, serve the request first.
- P_ACC: mem_adrs and mem_wdata come from the captured values; mem_wr_en = captured wr. Go to P_WAIT.
- P_WAIT: mem_wr_en = 0. Capture mem_q into pr_rdata only on reads; writes leave pr_rdata unchanged. Pulse pr_done. Go to P_HOLD.
- P_HOLD: wait for pr_req = 0 so one held request is not served twice, then go to P_IDLE.
- RELEASE: one dead cycle with mem_wr_en = 0 and cpu_stall = 1. Go to RUN.
- mode_sync changes during P_ACC, P_WAIT or P_HOLD do not abort the access; the change is acted on in P_IDLE.
- Latency:
  - pr_gnt comes one cycle after pr_req is seen in P_IDLE.
  - pr_done comes 2 cycles after pr_gnt.
  - Handover, run to program: SYNC_STAGES + 1 + drain cycles.
  - Handover, program to run: SYNC_STAGES + 2 cycles.
- Reset asserted in any state, including mid-access, goes to RUN next cycle. Any in-flight programmer access is dropped with no pr_done.
- Addresses pass through unmodified; there is no wrap or arithmetic. The drain counter saturates at DRAIN_MAX.

Decomposition:
- Package mem_arb_pkg: state enum {RUN, DRAIN, P_IDLE, P_ACC, P_WAIT, P_HOLD, RELEASE} and default AW/DW constants.
- Sub-module sync_ff: a SYNC_STAGES-deep bit synchronizer with synchronous reset. It is reusable for the button inputs.
- All FSM, counter and mux logic stays in mem_port_arbiter.

Test Plan:
- Reset then idle, mode_sw = 0, with CPU write adrs=8'h10 data=8'hA5 → mem_wr_en = 1, mem_adrs = 8'h10, cpu_stall = 0, prog_mode = 0.
- mode_sw rises, cpu_endseq pulses on the 3rd DRAIN cycle → cpu_stall rises in the cycle after that endseq; prog_mode = 1.
- mode_sw rises, cpu_endseq held 0 → forced handover after exactly 15 DRAIN cycles.
- In program mode, write req adrs=8'h20 data=8'h3C, then read req adrs=8'h20 → pr_gnt, then pr_done 2 cycles later for each; read pr_rdata = 8'h3C.
- pr_req held high for 10 cycles after pr_done → only one mem_wr_en pulse occurs.
- Reset asserted during P_ACC → RUN next cycle, pr_done never pulses, cpu_stall = 0. Separately, mode_sw falls during P_WAIT → pr_done still pulses, then RELEASE, then RUN.
